// File: rtl/sdr_pkg.sv
// Shared definitions for the SDR sender path: state encoding, word width
// and the frame-length helper used by anything that needs to know how many
// serial bit slots a frame occupies.
package sdr_pkg;

  localparam int SDR_DATA_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } sdr_state_t;

  // Number of bit slots in one frame: start + data + optional parity + stop.
  function automatic int sdr_frame_bits(input int parity_en);
    return SDR_DATA_W + 2 + ((parity_en != 0) ? 1 : 0);
  endfunction

endpackage

// File: rtl/sdr_baud_tick.sv
// Baud counter for the serializer. Counts 0..CLKS_PER_BIT-1 and flags the
// last cycle of each bit slot. A synchronous clear holds it at 0 so the
// first bit of a frame always gets a full bit time.
module sdr_baud_tick #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic Reset_n,
  input  logic clear,
  output logic bit_end
);

  // Counter must hold CLKS_PER_BIT-1; at least one bit wide for the 2-cycle case.
  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;

  // Next count: clear or wrap at the end of a bit, otherwise advance.
  always_comb begin
    cnt_next = cnt_reg;
    if (clear || (cnt_reg == CNT_MAX)) begin
      cnt_next = '0;
    end else begin
      cnt_next = cnt_reg + CNT_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  // While cleared the counter is parked, so no bit can end.
  assign bit_end = !clear && (cnt_reg == CNT_MAX);

endmodule

// File: rtl/sdr_serializer.sv
// Serializer at the end of the sender path. Captures a word on Transmit and
// sends start, 16 data bits LSB first, optional even parity, stop. All outputs
// come straight from flops; the line level for the next cycle is derived from
// the next state so there is no input-to-output combinational path.
module sdr_serializer
  import sdr_pkg::*;
#(
  parameter int DATA_W       = SDR_DATA_W,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_EN    = 1
) (
  input  logic              clk,
  input  logic              Reset_n,
  input  logic              Transmit,
  input  logic [DATA_W-1:0] sdrDataIn,
  output logic              Ready,
  output logic              SerialOut,
  output logic              FrameDone
);

  localparam logic [3:0] LAST_BIT = 4'(DATA_W - 1);

  sdr_state_t        state_reg, state_next;
  logic [DATA_W-1:0] shift_reg, shift_next;
  logic [3:0]        bit_cnt_reg, bit_cnt_next;
  logic              parity_reg, parity_next;
  logic              serial_reg, serial_next;
  logic              ready_reg, ready_next;
  logic              done_reg, done_next;
  logic              baud_clear;
  logic              bit_end;

  // Baud timing restarts from zero on every capture, since IDLE holds it cleared.
  assign baud_clear = (state_reg == ST_IDLE);

  sdr_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk    (clk),
    .Reset_n(Reset_n),
    .clear  (baud_clear),
    .bit_end(bit_end)
  );

  // Frame sequencing plus the registered line, ready and done values.
  always_comb begin
    state_next   = state_reg;
    shift_next   = shift_reg;
    bit_cnt_next = bit_cnt_reg;
    parity_next  = parity_reg;
    done_next    = 1'b0;
    serial_next  = 1'b1;
    ready_next   = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        // Transmit while busy never reaches here, so it is ignored by construction.
        if (Transmit) begin
          state_next   = ST_START;
          shift_next   = sdrDataIn;
          parity_next  = ^sdrDataIn;
          bit_cnt_next = '0;
        end
      end
      ST_START: begin
        if (bit_end) begin
          state_next = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          shift_next   = shift_reg >> 1;
          bit_cnt_next = bit_cnt_reg + 4'd1;
          if (bit_cnt_reg == LAST_BIT) begin
            state_next = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
          end
        end
      end
      ST_PARITY: begin
        if (bit_end) begin
          state_next = ST_STOP;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          state_next = ST_IDLE;
          done_next  = 1'b1;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    // Line level for the slot the FSM is entering; idle and stop are both high.
    case (state_next)
      ST_START:  serial_next = 1'b0;
      ST_DATA:   serial_next = shift_next[0];
      ST_PARITY: serial_next = parity_next;
      default:   serial_next = 1'b1;
    endcase

    ready_next = (state_next == ST_IDLE);
  end

  // State, datapath and output registers; reset abandons any frame in flight.
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_reg   <= ST_IDLE;
      shift_reg   <= '0;
      bit_cnt_reg <= '0;
      parity_reg  <= 1'b0;
      serial_reg  <= 1'b1;
      ready_reg   <= 1'b1;
      done_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      shift_reg   <= shift_next;
      bit_cnt_reg <= bit_cnt_next;
      parity_reg  <= parity_next;
      serial_reg  <= serial_next;
      ready_reg   <= ready_next;
      done_reg    <= done_next;
    end
  end

  assign Ready     = ready_reg;
  assign SerialOut = serial_reg;
  assign FrameDone = done_reg;

endmodule

// File: tb/tb_sdr_serializer.sv
// Scoreboard bench for sdr_serializer. Two instances (parity on / parity off)
// share clock and reset. Stimulus pushes {parity, word} expectations; a
// per-instance monitor pops one on every frame start and checks every bit slot.
`timescale 1ns/1ps
module tb_sdr_serializer;
  import sdr_pkg::*;

  localparam int CPB  = 4;
  localparam int NDUT = 2;

  logic        clk = 1'b0;
  logic        Reset_n;
  logic        tx   [NDUT];
  logic [15:0] din  [NDUT];
  logic        rdy  [NDUT];
  logic        ser  [NDUT];
  logic        done [NDUT];

  logic [16:0] exp_q [NDUT][$];   // {parity bit, word}, hand computed
  int          n_cmp = 0;
  int          n_fail = 0;
  int          n_done [NDUT];
  int          gap    [NDUT];
  int          cyc = 0;

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  sdr_serializer #(.DATA_W(16), .CLKS_PER_BIT(CPB), .PARITY_EN(1)) dut_p (
    .clk(clk), .Reset_n(Reset_n), .Transmit(tx[0]), .sdrDataIn(din[0]),
    .Ready(rdy[0]), .SerialOut(ser[0]), .FrameDone(done[0])
  );

  sdr_serializer #(.DATA_W(16), .CLKS_PER_BIT(CPB), .PARITY_EN(0)) dut_n (
    .clk(clk), .Reset_n(Reset_n), .Transmit(tx[1]), .sdrDataIn(din[1]),
    .Ready(rdy[1]), .SerialOut(ser[1]), .FrameDone(done[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  for (genvar gi = 0; gi < NDUT; gi++) begin : g_mon
    localparam int PE    = (gi == 0) ? 1 : 0;
    localparam int NBITS = sdr_frame_bits(PE);

    // Frame monitor: pops one expectation per frame start and checks each slot.
    initial begin : frame_mon
      logic        rdy_prev;
      logic [16:0] e;
      logic        exp_bits [20];
      logic        aborted, ok, has_exp;
      logic        bad_s, bad_r, bad_d;
      int          last_end;
      rdy_prev = 1'b1;
      last_end = -1000;
      forever begin
        @(negedge clk);
        if (!Reset_n) begin
          rdy_prev = 1'b1;
        end else if (rdy_prev && !rdy[gi]) begin
          gap[gi] = cyc - last_end;
          has_exp = (exp_q[gi].size() != 0);
          if (!has_exp) begin
            n_cmp++;
            n_fail++;
            $display("FAIL dut%0d_unexpected_frame: got frame start, required none", gi);
            rdy_prev = 1'b0;
          end else begin
            e = exp_q[gi].pop_front();
            exp_bits[0] = 1'b0;
            for (int k = 0; k < 16; k++) exp_bits[1 + k] = e[k];
            if (PE != 0) exp_bits[17] = e[16];
            exp_bits[NBITS - 1] = 1'b1;
            aborted = 1'b0;
            for (int b = 0; b < NBITS; b++) begin
              if (!aborted) begin
                ok = 1'b1;
                bad_s = 1'b0; bad_r = 1'b0; bad_d = 1'b0;
                for (int c = 0; c < CPB; c++) begin
                  if (!aborted) begin
                    if ((b != 0) || (c != 0)) @(negedge clk);
                    if (!Reset_n) begin
                      aborted = 1'b1;
                    end else if (ok && ((ser[gi] !== exp_bits[b]) || (rdy[gi] !== 1'b0) || (done[gi] !== 1'b0))) begin
                      ok = 1'b0;
                      bad_s = ser[gi]; bad_r = rdy[gi]; bad_d = done[gi];
                    end
                  end
                end
                if (!aborted) begin
                  n_cmp++;
                  if (!ok) begin
                    n_fail++;
                    $display("FAIL dut%0d_word%h_slot%0d: got line=%b ready=%b done=%b, required line=%b ready=0 done=0",
                             gi, e[15:0], b, bad_s, bad_r, bad_d, exp_bits[b]);
                  end
                end
              end
            end
            if (aborted) begin
              $display("dut%0d frame %h abandoned by reset", gi, e[15:0]);
              rdy_prev = 1'b1;
            end else begin
              @(negedge clk);
              if (!Reset_n) begin
                rdy_prev = 1'b1;
              end else begin
                check($sformatf("dut%0d_frame_end_rdy_done_line", gi),
                      {29'd0, rdy[gi], done[gi], ser[gi]}, 32'h7);
                last_end = cyc;
                $display("dut%0d frame %h parity %b sent", gi, e[15:0], e[16]);
                rdy_prev = rdy[gi];
              end
            end
          end
        end else begin
          rdy_prev = rdy[gi];
        end
      end
    end

    // FrameDone counter and single-cycle pulse width check.
    initial begin : done_mon
      logic done_prev;
      done_prev = 1'b0;
      n_done[gi] = 0;
      forever begin
        @(negedge clk);
        if (done_prev) check($sformatf("dut%0d_done_width", gi), {31'd0, done[gi]}, 32'd0);
        if (done[gi] === 1'b1) n_done[gi]++;
        done_prev = (done[gi] === 1'b1);
      end
    end
  end

  task automatic send(input int gi, input logic [15:0] w, input logic p, input int hold);
    exp_q[gi].push_back({p, w});
    @(posedge clk); #1;
    tx[gi]  = 1'b1;
    din[gi] = w;
    repeat (hold) @(posedge clk);
    #1 tx[gi] = 1'b0;
  endtask

  task automatic wait_done(input int gi, input int target, input int limit);
    int k;
    k = 0;
    while ((n_done[gi] < target) && (k < limit)) begin
      @(negedge clk);
      k++;
    end
    check($sformatf("dut%0d_done_count", gi), n_done[gi], target);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic quiet;
    int   k;
    Reset_n = 1'b0;
    for (int i = 0; i < NDUT; i++) begin
      tx[i] = 1'b0;
      din[i] = 16'h0000;
    end

    // 1. Reset and idle quiet period
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < NDUT; i++)
      check($sformatf("dut%0d_in_reset", i), {29'd0, rdy[i], ser[i], done[i]}, 32'h6);
    Reset_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < NDUT; i++)
      check($sformatf("dut%0d_after_reset", i), {29'd0, rdy[i], ser[i], done[i]}, 32'h6);
    quiet = 1'b1;
    repeat (20) begin
      @(negedge clk);
      for (int i = 0; i < NDUT; i++)
        if ((rdy[i] !== 1'b1) || (ser[i] !== 1'b1) || (done[i] !== 1'b0)) quiet = 1'b0;
    end
    check("idle_quiet", {31'd0, quiet}, 32'd1);

    // 2. Single frame A5C3, eight ones -> parity 0
    send(0, 16'hA5C3, 1'b0, 1);
    wait_done(0, 1, 200);

    // 3. Parity 1 with 0001, then the same word with parity disabled
    send(0, 16'h0001, 1'b1, 1);
    wait_done(0, 2, 200);
    send(1, 16'h0001, 1'b0, 1);
    wait_done(1, 1, 200);

    // 4. Three-cycle pulse, data changed after capture (3C5A has eight ones)
    exp_q[0].push_back({1'b0, 16'h3C5A});
    @(posedge clk); #1;
    tx[0] = 1'b1;
    din[0] = 16'h3C5A;
    @(posedge clk); #1;
    @(posedge clk); #1;
    din[0] = 16'hFFFF;
    @(posedge clk); #1;
    tx[0] = 1'b0;
    wait_done(0, 3, 200);

    // 5. Back-to-back with Transmit held: 1234 (five ones) then 5678 (eight ones)
    exp_q[0].push_back({1'b1, 16'h1234});
    exp_q[0].push_back({1'b0, 16'h5678});
    @(posedge clk); #1;
    tx[0] = 1'b1;
    din[0] = 16'h1234;
    @(posedge clk); #1;
    din[0] = 16'h5678;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while ((rdy[0] !== 1'b1) && (k < 200));
    @(posedge clk); #1;
    tx[0] = 1'b0;
    wait_done(0, 5, 200);
    check("b2b_idle_gap", gap[0], 1);

    // 6. Reset during data bit 7 of 00FF, then a clean retry
    exp_q[0].push_back({1'b0, 16'h00FF});
    @(posedge clk); #1;
    tx[0] = 1'b1;
    din[0] = 16'h00FF;
    @(posedge clk); #1;
    tx[0] = 1'b0;
    repeat (32) @(posedge clk);
    #2 Reset_n = 1'b0;
    #1;
    check("midreset_line", {31'd0, ser[0]}, 32'd1);
    check("midreset_ready", {31'd0, rdy[0]}, 32'd1);
    check("midreset_done", {31'd0, done[0]}, 32'd0);
    repeat (2) @(posedge clk);
    #1 Reset_n = 1'b1;
    repeat (60) @(negedge clk);
    check("no_done_after_abort", n_done[0], 5);
    send(0, 16'h00FF, 1'b0, 1);
    wait_done(0, 6, 200);

    repeat (5) @(negedge clk);
    for (int i = 0; i < NDUT; i++)
      check($sformatf("dut%0d_queue_drained", i), exp_q[i].size(), 0);
    check("dut1_total_frames", n_done[1], 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/sdr_serializer.md
# sdr_serializer

Downstream stage of the sender control FSM: captures one 16-bit word from `sdrDataIn` on a `Transmit` request and shifts it out as an asynchronous serial frame: start bit, 16 data bits LSB first, optional even parity, stop bit. It drives `Ready` back to the controller so the controller can pace successive memory reads. It is the last block before the transmit pin.

## Interface
- `DATA_W`, 16, word width; fixed at 16 for this design.
- `CLKS_PER_BIT`, 4, clock cycles per serial bit; legal range 2..65535.
- `PARITY_EN`, 1, 1 inserts an even-parity bit after the data; 0 omits it.

- `clk`  in  1  single system clock, rising edge
- `Reset_n`  in  1  asynchronous, active-low reset
- `Transmit`  in  1  start request from the controller
- `sdrDataIn`  in  16  word to send; sampled only at capture
- `Ready`  out  1  high when idle and able to accept a word
- `SerialOut`  out  1  serial line; idle level is 1
- `FrameDone`  out  1  one-cycle pulse at the end of each frame

## Operation
- **Reset values:** `Ready`=1, `SerialOut`=1, `FrameDone`=0. Internal state is IDLE, with bit counter, baud counter and shift register all 0.
- **States:**
  - IDLE: `Transmit`=1 loads the shift register with `sdrDataIn`, computes parity as the XOR of all bits, goes to START and sets `Ready`=0.
  - START: drives 0 for one bit time, then goes to DATA.
  - DATA: drives the shift register LSB. At each bit end it shifts right and increments the bit counter. After bit 15 it goes to PARITY if `PARITY_EN`, else to STOP.
  - PARITY: drives the even-parity bit for one bit time, then goes to STOP.
  - STOP: drives 1 for one bit time, then returns to IDLE with `Ready`=1 and `FrameDone`=1.
- **Bit timing:** the baud counter counts 0..`CLKS_PER_BIT`-1. A bit ends when the count reaches `CLKS_PER_BIT`-1; the counter then wraps to 0.
- **Transmit while busy:** ignored. A controller pulse of 1–3 cycles starts exactly one frame.
- **Transmit held high:** if `Transmit` is still 1 in the first IDLE cycle, a new frame starts immediately with the current `sdrDataIn`.
- **Data stability:** `sdrDataIn` changes after capture have no effect on the frame in progress.
- **Async reset mid-frame:** outputs return to their reset values immediately and the frame is abandoned. No `FrameDone` is issued.

## Timing
- All outputs are registered. There is no combinational path from any input to any output.
- **Capture:** `Transmit` sampled at 1 on edge N (state IDLE). After edge N, `Ready`=0 and `SerialOut`=0, the start bit.
- **Frame length:** F = (18 + `PARITY_EN`) × `CLKS_PER_BIT` cycles, measured from the first start-bit cycle to the last stop-bit cycle.
- **Data bit k:** valid on `SerialOut` for cycles (1+k)·`CLKS_PER_BIT` .. (2+k)·`CLKS_PER_BIT`-1, counted from the start-bit cycle.
- **Frame end:** `Ready`=1 and `FrameDone`=1 in cycle F, the cycle after the last stop cycle. `FrameDone` returns to 0 in cycle F+1.
- **Back-to-back:** the earliest next capture is the edge ending cycle F. Minimum frame period is F+1 cycles; the extra cycle is the idle-high cycle.

## Structure
- **Shared package `sdr_pkg`:** state encoding (IDLE=0, START=1, DATA=2, PARITY=3, STOP=4, in 3 bits), `SDR_DATA_W`=16, and a frame-bit-count function of `PARITY_EN`. The sender control block also imports `SDR_DATA_W` from this package.
- **Sub-module `sdr_baud_tick`:** baud counter with a synchronous clear and a one-cycle `bit_end` output. Parameterised by `CLKS_PER_BIT`.
- **Top level:** FSM, 16-bit shift register, 4-bit bit counter and parity register.

## Test plan
1. **Reset:** assert `Reset_n`=0 for 3 cycles, then release → `Ready`=1, `SerialOut`=1, `FrameDone`=0, with no activity over 20 idle cycles.
2. **Single frame:** `CLKS_PER_BIT`=4, `PARITY_EN`=1, `sdrDataIn`=16'hA5C3, one-cycle `Transmit` → `SerialOut` shows 0, then 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1, then parity 0, then stop 1. Each bit lasts 4 cycles. `Ready` is low for 76 cycles, then `FrameDone` pulses for exactly 1 cycle.
3. **Parity 1, parity off:** with `PARITY_EN`=1, 16'h0001 → parity bit 1. With `PARITY_EN`=0, the same word → frame of 72 cycles with no parity slot.
4. **Controller-style pulse:** `Transmit` held for 3 cycles, `sdrDataIn` changed to 16'hFFFF one cycle after capture → exactly one frame, carrying the originally captured word.
5. **Back-to-back:** `Transmit` held high continuously with words 16'h1234 then 16'h5678 → two frames separated by exactly 1 idle-high cycle. `FrameDone` pulses twice.
6. **Mid-frame reset:** assert `Reset_n` low during data bit 7 of 16'h00FF → `SerialOut`=1 and `Ready`=1 immediately, no `FrameDone`. A fresh `Transmit` after release produces a complete, correct frame.
